// File: rtl/lod_pkg.sv
// Shared constants and result bundle for the leading-one detector
// and the log converter that consumes it.
package lod_pkg;

    localparam int DEF_LOG2_WIDTH = 4;
    localparam int DEF_WIDTH      = 2 ** DEF_LOG2_WIDTH;
    localparam int DEF_GROUP_W    = 4;
    localparam int DEF_NGRP       = DEF_WIDTH / DEF_GROUP_W;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]      operand;
        logic [DEF_LOG2_WIDTH-1:0] k;
        logic                      zero;
    } lod_res_t;

endpackage

// File: rtl/lod_group.sv
// Combinational priority encoder for one operand group:
// reports whether any bit is set and the local MSB index.
module lod_group #(
    parameter int GROUP_W = 4,
    parameter int IDX_W   = (GROUP_W > 1) ? $clog2(GROUP_W) : 1
) (
    input  logic [GROUP_W-1:0] grp_i,
    output logic               nz_o,
    output logic [IDX_W-1:0]   idx_o
);

    assign nz_o = |grp_i;

    // Highest set bit wins; index stays 0 for an all-zero group
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < GROUP_W; i++) begin
            if (grp_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/lod_pipe.sv
// Two-stage leading-one detector: S1 encodes per-group MSBs,
// S2 picks the highest non-zero group and forms K.
module lod_pipe
    import lod_pkg::*;
#(
    parameter int LOG2_WIDTH = DEF_LOG2_WIDTH,
    parameter int WIDTH      = 2 ** LOG2_WIDTH,
    parameter int GROUP_W    = DEF_GROUP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_operand,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_operand,
    output logic [LOG2_WIDTH-1:0] out_k,
    output logic                  out_zero
);

    localparam int NGRP  = WIDTH / GROUP_W;
    localparam int IDX_W = (GROUP_W > 1) ? $clog2(GROUP_W) : 1;

    logic                            s1_valid_q;
    logic                            s1_valid_d;
    logic [WIDTH-1:0]                s1_op_q;
    logic [NGRP-1:0]                 s1_nz_q;
    logic [NGRP-1:0][IDX_W-1:0]      s1_idx_q;
    logic [NGRP-1:0]                 grp_nz_d;
    logic [NGRP-1:0][IDX_W-1:0]      grp_idx_d;

    logic                            s2_valid_q;
    logic                            s2_valid_d;
    logic [WIDTH-1:0]                s2_op_q;
    logic [LOG2_WIDTH-1:0]           s2_k_q;
    logic [LOG2_WIDTH-1:0]           s2_k_d;
    logic                            s2_zero_q;
    logic                            s2_zero_d;

    logic                            s1_adv;
    logic                            accept;

    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;

    assign out_valid   = s2_valid_q;
    assign out_operand = s2_op_q;
    assign out_k       = s2_k_q;
    assign out_zero    = s2_zero_q;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        lod_group #(
            .GROUP_W (GROUP_W),
            .IDX_W   (IDX_W)
        ) u_grp (
            .grp_i (in_operand[g*GROUP_W +: GROUP_W]),
            .nz_o  (grp_nz_d[g]),
            .idx_o (grp_idx_d[g])
        );
    end

    // Next valid bits: S1 fills on accept, empties when it drains
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
        end
    end

    // Highest non-zero group supplies the upper K bits
    always_comb begin
        s2_k_d = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (s1_nz_q[g]) begin
                s2_k_d = LOG2_WIDTH'(g * GROUP_W)
                       | LOG2_WIDTH'(s1_idx_q[g]);
            end
        end
        s2_zero_d = ~|s1_nz_q;
    end

    // S1 register: operand and per-group encodings
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_nz_q    <= '0;
            s1_idx_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_op_q  <= in_operand;
                s1_nz_q  <= grp_nz_d;
                s1_idx_q <= grp_idx_d;
            end
        end
    end

    // S2 register: result presented to the converter
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_op_q    <= '0;
            s2_k_q     <= '0;
            s2_zero_q  <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s1_adv && s1_valid_q) begin
                s2_op_q   <= s1_op_q;
                s2_k_q    <= s2_k_d;
                s2_zero_q <= s2_zero_d;
            end
        end
    end

endmodule
